if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 47 ++++
 rtl/if_stage_if.sv | 10 +
 rtl/if_id_register.sv | 25 ++
 rtl/if_stage.sv | 83 ++++++++
 tb/tb_if_stage.sv | 134 +++++++++++++
 5 files changed

// File: rtl/if_stage_pkg.sv
// Shared RV32I definitions used by the IF, ID and EX stages: reset/bubble
// constants, instruction field positions and the IF/ID payload type.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0

  // Field positions of the RV32I base encoding.
  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;
  localparam int IMM_LSB    = 7;
  localparam int IMM_MSB    = 31;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b000_0011,
    OP_IMM    = 7'b001_0011,
    OP_AUIPC  = 7'b001_0111,
    OP_STORE  = 7'b010_0011,
    OP_REG    = 7'b011_0011,
    OP_LUI    = 7'b011_0111,
    OP_BRANCH = 7'b110_0011,
    OP_JALR   = 7'b110_0111,
    OP_JAL    = 7'b110_1111
  } opcode_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and the external imem.
interface if_stage_if;

  logic [31:0] ImemAddrF;
  logic [31:0] ImemRdataF;

  modport master (output ImemAddrF, input ImemRdataF);
  modport slave  (input  ImemAddrF, output ImemRdataF);

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush/reset load a bubble, stall holds, else capture.
module if_id_register
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      q <= '{instr: NOP_INSTR, pc: 32'd0, pc_plus4: 32'd0, valid: 1'b0};
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection and the
// IF/ID register with combinational decode-field slices of InstrD.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallF,
  input  logic              StallD,
  input  logic              FlushD,
  input  logic              PCSrcE,
  input  logic [31:0]       PCTargetE,
  if_stage_if.master        imem,
  output logic [31:0]       InstrD,
  output logic [31:0]       PCD,
  output logic [31:0]       PCPlus4D,
  output logic              ValidD,
  output logic [6:0]        opcode,
  output logic [4:0]        RdD,
  output logic [2:0]        funct3,
  output logic [4:0]        a1,
  output logic [4:0]        a2,
  output logic [6:0]        funct7,
  output logic [24:0]       in_Extend
);

  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic [31:0] pc_next;
  if_id_t      fetch_d;
  if_id_t      decode_q;

  assign pc_plus4_f     = pc_plus4(pc_f);
  assign imem.ImemAddrF = pc_f;

  // A resolved redirect beats a fetch stall; targets are forced halfword aligned.
  always_comb begin
    pc_next = pc_plus4_f;
    if (PCSrcE) begin
      pc_next = PCTargetE & ~32'd1;
    end else if (StallF) begin
      pc_next = pc_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= RESET_PC;
    end else begin
      pc_f <= pc_next;
    end
  end

  assign fetch_d = '{instr: imem.ImemRdataF, pc: pc_f, pc_plus4: pc_plus4_f, valid: 1'b1};

  if_id_register #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_register (
    .clk   (clk),
    .reset (reset),
    .stall (StallD),
    .flush (FlushD),
    .d     (fetch_d),
    .q     (decode_q)
  );

  assign InstrD   = decode_q.instr;
  assign PCD      = decode_q.pc;
  assign PCPlus4D = decode_q.pc_plus4;
  assign ValidD   = decode_q.valid;

  assign opcode    = InstrD[OPCODE_MSB:OPCODE_LSB];
  assign RdD       = InstrD[RD_MSB:RD_LSB];
  assign funct3    = InstrD[FUNCT3_MSB:FUNCT3_LSB];
  assign a1        = InstrD[RS1_MSB:RS1_LSB];
  assign a2        = InstrD[RS2_MSB:RS2_LSB];
  assign funct7    = InstrD[FUNCT7_MSB:FUNCT7_LSB];
  assign in_Extend = InstrD[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Table-driven bench for if_stage; imem returns addr+1 so word i reads i*4+1.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  opcode, funct7;
  logic [4:0]  RdD, a1, a2;
  logic [2:0]  funct3;
  logic [24:0] in_Extend;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  if_stage_if imem ();
  assign imem.ImemRdataF = imem.ImemAddrF + 32'd1;

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD),
    .opcode    (opcode),
    .RdD       (RdD),
    .funct3    (funct3),
    .a1        (a1),
    .a2        (a2),
    .funct7    (funct7),
    .in_Extend (in_Extend)
  );

  typedef struct {
    logic        rst, sf, sd, fd, ps;
    logic [31:0] tgt;
    logic [31:0] e_pc, e_instr, e_pcd, e_p4d;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic add(input logic rst, sf, sd, fd, ps, input logic [31:0] tgt,
                     input logic [31:0] e_pc, e_instr, e_pcd, e_p4d, input logic e_v);
    vec_t v;
    v = '{rst: rst, sf: sf, sd: sd, fd: fd, ps: ps, tgt: tgt,
          e_pc: e_pc, e_instr: e_instr, e_pcd: e_pcd, e_p4d: e_p4d, e_v: e_v};
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, sf, sd, fd, ps, input logic [31:0] tgt);
    @(negedge clk);
    reset = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc, e_instr, e_pcd, e_p4d,
                             input logic e_v);
    logic [31:0] fields;
    check({tag, "_pcf"},    imem.ImemAddrF, e_pc);
    check({tag, "_instr"},  InstrD, e_instr);
    check({tag, "_pcd"},    PCD, e_pcd);
    check({tag, "_p4d"},    PCPlus4D, e_p4d);
    check({tag, "_valid"},  {31'd0, ValidD}, {31'd0, e_v});
    fields = {funct7, a2, a1, funct3, RdD, opcode};
    check({tag, "_fields"}, fields, e_instr);
    check({tag, "_ext"},    {7'd0, in_Extend}, {7'd0, e_instr[31:7]});
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'd0;

    //  rst sf sd fd ps target        pcf           instr         pcd           p4d           v
    add(1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h13,       32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h0,        32'h4,        1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h8,        32'h5,        32'h4,        32'h8,        1);
    add(0, 0, 0, 0, 0, 32'h0,        32'hC,        32'h9,        32'h8,        32'hC,        1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h10,       32'hD,        32'hC,        32'h10,       1);
    add(0, 1, 1, 0, 0, 32'h0,        32'h10,       32'hD,        32'hC,        32'h10,       1);
    add(0, 1, 1, 0, 0, 32'h0,        32'h10,       32'hD,        32'hC,        32'h10,       1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h14,       32'h11,       32'h10,       32'h14,       1);
    add(0, 1, 0, 1, 1, 32'h101,      32'h100,      32'h13,       32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h104,      32'h101,      32'h100,      32'h104,      1);
    add(0, 0, 1, 1, 0, 32'h0,        32'h108,      32'h13,       32'h0,        32'h0,        0);
    add(0, 0, 1, 0, 0, 32'h0,        32'h10C,      32'h13,       32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h10D,    32'h10C,      32'h110,      1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h0,        32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h0,       1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h0,        32'h4,        1);
    add(1, 1, 1, 0, 1, 32'h200,      32'h0,        32'h13,       32'h0,        32'h0,        0);
    add(0, 0, 0, 0, 0, 32'h0,        32'h4,        32'h1,        32'h0,        32'h4,        1);
    add(0, 0, 0, 0, 1, 32'h203,      32'h202,      32'h5,        32'h4,        32'h8,        1);
    add(0, 0, 0, 0, 0, 32'h0,        32'h206,      32'h203,      32'h202,      32'h206,      1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].sf, vecs[i].sd, vecs[i].fd, vecs[i].ps, vecs[i].tgt);
      check_state($sformatf("row%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd,
                  vecs[i].e_p4d, vecs[i].e_v);
    end

    // Fetch-only stall: PC holds while IF/ID keeps re-capturing the same word.
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0, 0, 0, 32'h0);
      check_state($sformatf("stallf%0d", k), 32'h206, 32'h207, 32'h206, 32'h20A, 1'b1);
    end
    step(0, 0, 0, 0, 0, 32'h0);
    check_state("stallf_rel", 32'h20A, 32'h207, 32'h206, 32'h20A, 1'b1);

    // Reset held for several cycles with a redirect pending stays parked at RESET_PC.
    step(1, 0, 0, 0, 1, 32'h400);
    step(1, 0, 0, 0, 1, 32'h400);
    check_state("rst_hold", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
